// File: rtl/lockin_demod.sv
//------------------------------------------------------------------------------
// Module   : lockin_demod
// Brief    : Quadrature demodulator and reference generator. An NCO phase
//            accumulator advances once per ADC sample. A quarter-wave sine LUT
//            supplies sin/cos, and these multiply the sample into X/Y products
//            for the downstream CIC decimators. The same sin value also drives
//            the offset-binary reference DAC.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lockin_demod #(
    parameter int DW   = 16,
    parameter int PW   = 32,
    parameter int LUTW = 8,
    parameter int SW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DW-1:0]    sample_i,
    input  logic                    sample_valid,
    input  logic [2:0]              reffreq,
    input  logic [1:0]              refampl,
    output logic signed [DW+SW-1:0] X_o,
    output logic signed [DW+SW-1:0] Y_o,
    output logic                    out_valid,
    output logic                    phase_wrap,
    output logic [SW-1:0]           ref_out
);

    localparam logic signed [SW-1:0] FS       = SW'((2 ** (SW - 1)) - 1);
    localparam logic [SW-1:0]        MIDSCALE = SW'(2 ** (SW - 1));

    // Elaboration-time table entry: round(FS * sin(pi/2 * k / 2^LUTW))
    function automatic logic signed [SW-1:0] lut_val(input int k);
        real r;
        r = ((2.0 ** (SW - 1)) - 1.0) *
            $sin(3.14159265358979323846 / 2.0 * k / (2.0 ** LUTW));
        return SW'($rtoi(r + 0.5));
    endfunction

    // Quadrant fold: 'near' is lut[a], 'far' is lut[2^LUTW - a]
    function automatic logic signed [SW-1:0] fold(
        input logic [1:0]           q,
        input logic                 a_zero,
        input logic signed [SW-1:0] near,
        input logic signed [SW-1:0] far
    );
        logic signed [SW-1:0] r;
        case (q)
            2'd0:    r = near;
            2'd1:    r = a_zero ? FS : far;
            2'd2:    r = -near;
            default: r = a_zero ? -FS : -far;
        endcase
        return r;
    endfunction

    logic signed [SW-1:0] lut [2**LUTW];

    for (genvar k = 0; k < 2**LUTW; k++) begin : g_lut
        localparam logic signed [SW-1:0] LUT_VAL = lut_val(k);
        assign lut[k] = LUT_VAL;
    end

    // NCO state
    logic [PW-1:0]          phase_q;
    logic                   wrap_pend_q;
    logic [PW-1:0]          inc_d;
    logic [PW-1:0]          phase_d;
    logic                   carry_d;

    // Stage 1: only the phase bits the LUT needs are carried forward
    logic                   s1_valid_q;
    logic signed [DW-1:0]   s1_sample_q;
    logic [LUTW+1:0]        s1_phase_q;
    logic                   s1_wrap_q;
    logic [1:0]             s1_ampl_q;

    // Stage 2
    logic                   s2_valid_q;
    logic signed [DW-1:0]   s2_sample_q;
    logic signed [SW-1:0]   s2_sin_q;
    logic signed [SW-1:0]   s2_cos_q;
    logic                   s2_wrap_q;
    logic [1:0]             s2_ampl_q;

    logic [1:0]             q_d;
    logic [LUTW-1:0]        a_d;
    logic [LUTW-1:0]        a_mirror_d;
    logic signed [SW-1:0]   sin_d;
    logic signed [SW-1:0]   cos_d;
    logic signed [DW+SW-1:0] x_d;
    logic signed [DW+SW-1:0] y_d;
    logic [SW-1:0]          ref_d;

    // Increment is a single power of two; the carry out marks the next sample as first after wrap
    always_comb begin
        inc_d              = PW'(1) << (5'd20 + 5'(reffreq));
        {carry_d, phase_d} = {1'b0, phase_q} + {1'b0, inc_d};
    end

    // Phase accumulator advances only on accepted samples; phase 0 after reset counts as a wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= '0;
            wrap_pend_q <= 1'b1;
        end else if (sample_valid) begin
            phase_q     <= phase_d;
            wrap_pend_q <= carry_d;
        end
    end

    // S1: capture sample, its phase, wrap flag and amplitude select
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= sample_valid;
        end
        if (sample_valid) begin
            s1_sample_q <= sample_i;
            s1_phase_q  <= phase_q[PW-1 -: LUTW+2];
            s1_wrap_q   <= wrap_pend_q;
            s1_ampl_q   <= refampl;
        end
    end

    // Quadrant decode; cos is the same lookup a quarter turn ahead
    always_comb begin
        q_d        = s1_phase_q[LUTW+1 -: 2];
        a_d        = s1_phase_q[LUTW-1:0];
        a_mirror_d = ~a_d + 1'b1;
        sin_d      = fold(q_d,        a_d == '0, lut[a_d], lut[a_mirror_d]);
        cos_d      = fold(q_d + 2'd1, a_d == '0, lut[a_d], lut[a_mirror_d]);
    end

    // S2: register folded sin/cos alongside the sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
        end
        if (s1_valid_q) begin
            s2_sample_q <= s1_sample_q;
            s2_sin_q    <= sin_d;
            s2_cos_q    <= cos_d;
            s2_wrap_q   <= s1_wrap_q;
            s2_ampl_q   <= s1_ampl_q;
        end
    end

    // Full-width signed products and scaled offset-binary reference
    always_comb begin
        x_d   = (DW+SW)'(s2_sample_q) * (DW+SW)'(s2_sin_q);
        y_d   = (DW+SW)'(s2_sample_q) * (DW+SW)'(s2_cos_q);
        ref_d = $unsigned(s2_sin_q >>> (2'd3 - s2_ampl_q)) + MIDSCALE;
    end

    // S3: outputs update only on a valid sample and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            X_o        <= '0;
            Y_o        <= '0;
            out_valid  <= 1'b0;
            phase_wrap <= 1'b0;
            ref_out    <= MIDSCALE;
        end else begin
            out_valid  <= s2_valid_q;
            phase_wrap <= s2_valid_q & s2_wrap_q;
            if (s2_valid_q) begin
                X_o     <= x_d;
                Y_o     <= y_d;
                ref_out <= ref_d;
            end
        end
    end

endmodule

`default_nettype wire
